bcd_display_driver: RTL
=======================

// Module: bcd_display_driver
// PURPOSE
//  Parametrised successor to the fixed 4-digit tho/hun/ten/one display path.
//  Converts a DATA_W-bit unsigned binary value (e.g. register or ALU result) to
//  packed BCD with a sequential double-dabble engine. The BCD digits then drive
//  DIGITS multiplexed, active-low, common-anode seven-segment displays.
//  Sits between processor debug taps and board display pins.
// PARAMETERS
//  DATA_W       16     binary input width; max value 2^DATA_W-1
//  DIGITS       5      BCD digits / displays; must satisfy 10^DIGITS > 2^DATA_W-1
//  REFRESH_DIV  50000  clk cycles each digit stays enabled before scan advances (>=2)
// PORTS
//  clk       in   1          system clock, rising edge
//  reset     in   1          asynchronous, active-high reset
//  value_in  in   DATA_W     binary value to convert, sampled when load accepted
//  load      in   1          conversion request; accepted only when busy=0
//  busy      out  1          conversion in progress
//  done      out  1          1-cycle pulse when bcd_out updates
//  bcd_out   out  4*DIGITS   packed BCD, digit 0 (ones) in [3:0]
//  seg       out  7          {g,f,e,d,c,b,a}, active low
//  an        out  DIGITS     digit enable, one-hot active low
// BEHAVIOUR
//  Reset values:
//   - busy=0, done=0, bcd_out=0, scan index=0, refresh counter=0.
//   - an={DIGITS{1}} with bit0=0; seg=7'b1000000 (digit '0').
//  FSM states:
//   - IDLE: load=1 -> capture value_in into shift reg; clear BCD scratch;
//     clear shift count; go SHIFT.
//   - SHIFT: each cycle, first add 3 to every scratch nibble >=5.
//     Then shift {scratch,shift reg} left 1 in the same cycle.
//     After DATA_W shifts, go DONE.
//   - DONE: bcd_out<=scratch; done=1 for this cycle only; go IDLE.
//  busy=1 in SHIFT and DONE.
//  Latency: load sampled at edge N -> done high in cycle N+DATA_W+1.
//  A new load is accepted on the edge after done.
//  load while busy: ignored; no queueing; running conversion unaffected.
//  bcd_out holds its previous value during conversion (display does not flicker).
//  Scan:
//   - Refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
//   - On wrap, scan index advances: DIGITS-1 wraps to 0.
//   - an = ~(1<<index).
//   - seg = decode of bcd_out nibble[index]; seg and an change on the same edge.
//  Decode table (active low):
//   - 0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//   - 5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//   - Nibble >9 (unreachable) -> 1111111.
//  reset mid-conversion: abort immediately to reset values; scratch discarded.
//  Width rule: scratch is 4*DIGITS bits; the top nibble never overflows under
//  the DIGITS constraint.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - For scanned digit k>0, seg=1111111 when digit k and every higher digit are 0.
//   - Digit 0 is always shown.
//   - an still scans all digits.
//  LEADING_ZERO_BLANK_EN undefined:
//   - All digits are decoded, leading zeros shown as '0'.
//  bcd_out is identical in both builds.
// TESTING
//  1. Load value 1234, defaults -> done 17 cycles after load edge;
//     bcd_out=20'h01234; done high exactly 1 cycle.
//  2. Load 65535 -> bcd_out=20'h65535.
//     Then load 0 -> bcd_out=20'h00000.
//  3. Load 42 at cycle 3 of a 1234 conversion -> ignored.
//     Result 20'h01234; busy drops after done.
//  4. REFRESH_DIV=4, bcd_out=20'h01234:
//     an steps 11110,11101,11011,10111,01111 every 4 cycles;
//     seg at index0 = 0011001.
//  5. reset pulse mid-SHIFT -> busy=0, done=0, bcd_out=0, an=11110,
//     seg=1000000, asynchronously.
//  6. Value 7 with LEADING_ZERO_BLANK_EN -> seg=1111111 for indices 1..4,
//     1111000 at index 0.
//     Without the macro -> 1000000 at indices 1..4.

Source files
------------

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) driving DIGITS multiplexed
// active-low common-anode seven-segment displays. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_display_driver #(
  parameter int DATA_W      = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0]  scratch_q, scratch_d;
  logic [4*DIGITS-1:0]  adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 done_q, done_d;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    adj       = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = value_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Add-3 correction and the left shift happen in the same cycle.
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan runs continuously, independent of the conversion FSM.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      ref_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [3:0]        cur_nib;
  logic [DIGITS-1:0] hi_zero;
  logic              zero_acc;
  logic              blank;

  always_comb begin
    cur_nib  = bcd_q[4*idx_q +: 4];
    zero_acc = 1'b1;
    hi_zero  = '0;
    // hi_zero[k] is set when digit k and every digit above it are zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_acc   = zero_acc & (bcd_q[4*k +: 4] == 4'd0);
      hi_zero[k] = zero_acc;
    end
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_q != '0) && hi_zero[idx_q];
`else
    blank = 1'b0;
`endif
    seg = blank ? 7'b1111111 : decode(cur_nib);
  end

  assign an      = ~(DIGITS'(1) << idx_q);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule
